// File: rtl/reduce_tree_pipe.sv
// rtl/reduce_tree_pipe.sv - pipelined binary reduction tree (sum/avg/max/min) over N_IN signed lanes
module reduce_tree_pipe #(
    parameter int N_IN = 32,
    parameter int W_IN = 16,
    localparam int LOG2N = $clog2(N_IN),
    localparam int W_OUT = W_IN + LOG2N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [1:0]             in_mode,
    input  logic [W_IN*N_IN-1:0]   in_data,
    output logic                   out_valid,
    output logic [1:0]             out_mode,
    output logic [W_OUT-1:0]       out_data
);

    for (genvar k = 1; k <= LOG2N; k++) begin : g_stage
        localparam int NK = N_IN >> k;
        localparam int WK = W_IN + k;
        localparam int WP = WK - 1;

        logic [NK*WK-1:0]   data_q;
        logic [NK*WK-1:0]   data_d;
        logic [1:0]         mode_q;
        logic               valid_q;
        logic [2*NK*WP-1:0] src_data;
        logic [1:0]         src_mode;
        logic               src_valid;

        if (k == 1) begin : g_src
            assign src_data  = in_data;
            assign src_mode  = in_mode;
            assign src_valid = in_valid;
        end else begin : g_src
            assign src_data  = g_stage[k-1].data_q;
            assign src_mode  = g_stage[k-1].mode_q;
            assign src_valid = g_stage[k-1].valid_q;
        end

        for (genvar j = 0; j < NK; j++) begin : g_ent
            logic [WP-1:0]        a_raw;
            logic [WP-1:0]        b_raw;
            logic signed [WK-1:0] a;
            logic signed [WK-1:0] b;
            logic signed [WK-1:0] s;
            logic signed [WK-1:0] r;

            assign a_raw = src_data[2*j*WP +: WP];
            assign b_raw = src_data[(2*j+1)*WP +: WP];
            assign a     = {a_raw[WP-1], a_raw};
            assign b     = {b_raw[WP-1], b_raw};
            assign s     = a + b;

            // Avg carries plain sums through the tree; only the last stage divides.
            always_comb begin
                r = s;
                case (src_mode)
                    2'b00: r = s;
                    2'b01: r = (k == LOG2N) ? (s >>> LOG2N) : s;
                    2'b10: r = (a > b) ? a : b;
                    2'b11: r = (a < b) ? a : b;
                    default: r = s;
                endcase
            end

            assign data_d[j*WK +: WK] = r;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                mode_q  <= 2'b00;
                data_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    mode_q <= src_mode;
                    data_q <= data_d;
                end
            end
        end
    end

    assign out_valid = g_stage[LOG2N].valid_q;
    assign out_mode  = g_stage[LOG2N].mode_q;
    assign out_data  = g_stage[LOG2N].data_q;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// tb/tb_reduce_tree_pipe.sv - self-checking bench for reduce_tree_pipe (N_IN=4, W_IN=8)
module tb_reduce_tree_pipe;
    localparam int N_IN = 4;
    localparam int W_IN = 8;
    localparam int W_OUT = 10;
    localparam int LAT = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic [1:0]           in_mode = 2'b00;
    logic [N_IN*W_IN-1:0] in_data = '0;
    logic                 out_valid;
    logic [1:0]           out_mode;
    logic [W_OUT-1:0]     out_data;

    reduce_tree_pipe #(.N_IN(N_IN), .W_IN(W_IN)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_mode(out_mode), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: in-flight vectors tagged with how many advancing edges they have seen.
    int q_age[$];
    int q_val[$];
    int q_mode[$];
    int exp_valid = 0;
    int exp_data = 0;
    int exp_mode = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    function automatic logic [31:0] pack4(int a, int b, int c, int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic int ref_calc(logic [1:0] m, logic [31:0] d);
        int s, mx, mn, v;
        s = 0;
        mx = -100000;
        mn = 100000;
        for (int i = 0; i < N_IN; i++) begin
            v = int'($signed(d[i*8 +: 8]));
            s += v;
            if (v > mx) mx = v;
            if (v < mn) mn = v;
        end
        case (m)
            2'b00: return s;
            2'b01: return s >>> 2;
            2'b10: return mx;
            default: return mn;
        endcase
    endfunction

    task automatic model_clear();
        q_age.delete();
        q_val.delete();
        q_mode.delete();
        exp_valid = 0;
        exp_data = 0;
        exp_mode = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
            return;
        end
        if (flush) begin
            q_age.delete();
            q_val.delete();
            q_mode.delete();
            exp_valid = 0;
            return;
        end
        if (!en) return;
        foreach (q_age[i]) q_age[i]++;
        while (q_age.size() > 0 && q_age[0] > LAT) begin
            void'(q_age.pop_front());
            void'(q_val.pop_front());
            void'(q_mode.pop_front());
        end
        if (in_valid) begin
            q_age.push_back(1);
            q_val.push_back(ref_calc(in_mode, in_data));
            q_mode.push_back(int'(in_mode));
        end
        exp_valid = 0;
        foreach (q_age[i]) begin
            if (q_age[i] == LAT) begin
                exp_valid = 1;
                exp_data = q_val[i];
                exp_mode = q_mode[i];
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic v, logic [1:0] m, logic [31:0] d);
        in_valid = v;
        in_mode = m;
        in_data = d;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_mode", int'(out_mode), 0);
            check("rst_out_data", sdata(), 0);
        end else begin
            check("cmp_out_valid", int'(out_valid), exp_valid);
            check("cmp_out_data", sdata(), exp_data);
            if (exp_valid != 0) check("cmp_out_mode", int'(out_mode), exp_mode);
        end
    end

    initial begin
        cycle();
        cycle();
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", sdata(), 0);
        rst = 1'b0;
        en = 1'b1;

        drive(1'b1, 2'b00, pack4(127, 127, 127, 127));
        cycle();
        drive(1'b0, 2'b00, '0);
        check("sum_not_early", int'(out_valid), 0);
        cycle();
        check("sum_valid", int'(out_valid), 1);
        check("sum_data", sdata(), 508);
        check("sum_mode", int'(out_mode), 0);

        drive(1'b1, 2'b01, pack4(1, 2, 3, -7));
        cycle();
        drive(1'b1, 2'b01, pack4(-128, -128, -128, -128));
        cycle();
        check("avg1_data", sdata(), -1);
        check("avg1_bits", int'(out_data), 'h3FF);
        check("avg1_mode", int'(out_mode), 1);
        drive(1'b0, 2'b00, '0);
        cycle();
        check("avg2_data", sdata(), -128);

        drive(1'b1, 2'b10, pack4(-5, 3, -100, 2));
        cycle();
        drive(1'b1, 2'b11, pack4(-5, 3, -100, 2));
        cycle();
        check("max_data", sdata(), 3);
        check("max_mode", int'(out_mode), 2);
        drive(1'b0, 2'b00, '0);
        cycle();
        check("min_data", sdata(), -100);
        check("min_bits", int'(out_data), 'h39C);
        check("min_mode", int'(out_mode), 3);

        drive(1'b1, 2'b00, pack4(10, 20, 30, 40));
        cycle();
        drive(1'b1, 2'b10, pack4(-1, -2, -3, -4));
        cycle();
        check("b2b_sum_data", sdata(), 100);
        check("b2b_sum_mode", int'(out_mode), 0);
        drive(1'b1, 2'b01, pack4(100, 100, 100, 101));
        cycle();
        check("b2b_max_valid", int'(out_valid), 1);
        check("b2b_max_data", sdata(), -1);
        check("b2b_max_mode", int'(out_mode), 2);
        drive(1'b0, 2'b00, '0);
        cycle();
        check("b2b_avg_data", sdata(), 100);
        check("b2b_avg_mode", int'(out_mode), 1);
        cycle();
        check("b2b_idle_valid", int'(out_valid), 0);
        check("b2b_hold_data", sdata(), 100);

        drive(1'b1, 2'b00, pack4(1, 2, 3, 4));
        cycle();
        drive(1'b0, 2'b00, '0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_no_valid", int'(out_valid), 0);
        end
        en = 1'b1;
        cycle();
        check("stall_late_valid", int'(out_valid), 1);
        check("stall_data", sdata(), 10);
        cycle();
        check("stall_after", int'(out_valid), 0);

        drive(1'b1, 2'b00, pack4(5, 5, 5, 5));
        cycle();
        drive(1'b1, 2'b00, pack4(7, 7, 7, 7));
        cycle();
        check("pre_flush_data", sdata(), 20);
        flush = 1'b1;
        drive(1'b1, 2'b00, pack4(9, 9, 9, 9));
        cycle();
        flush = 1'b0;
        drive(1'b0, 2'b00, '0);
        check("flush_valid0", int'(out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("flush_no_valid", int'(out_valid), 0);
        end

        drive(1'b1, 2'b00, pack4(1, 1, 1, 1));
        cycle();
        drive(1'b1, 2'b00, pack4(2, 2, 2, 2));
        cycle();
        check("pre_rst_data", sdata(), 4);
        #2 rst = 1'b1;
        #1 model_clear();
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_data", sdata(), 0);
        check("async_rst_mode", int'(out_mode), 0);
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b1, 2'b10, pack4(3, 3, 3, 3));
        cycle();
        drive(1'b0, 2'b00, '0);
        check("post_rst_no_stale", int'(out_valid), 0);
        cycle();
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_data", sdata(), 3);
        check("post_rst_mode", int'(out_mode), 2);

        for (int i = 0; i < 60; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            flush = 1'($urandom_range(0, 9) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom));
            cycle();
        end
        en = 1'b1;
        flush = 1'b0;
        drive(1'b0, 2'b00, '0);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reduce_tree_pipe.md
REDUCE_TREE_PIPE -- requirements
Module: reduce_tree_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 32: number of input lanes; power of two, minimum 2.
REQ-002 SHALL have parameter W_IN, default 16: lane width, signed two's complement.
REQ-003 SHALL derive localparam LOG2N = log2(N_IN), which is also the pipeline depth.
REQ-004 SHALL derive localparam W_OUT = W_IN+LOG2N.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1 bit: pipeline advance; low freezes all stages.
REQ-008 SHALL have port flush, input, 1 bit: synchronous invalidate of all in-flight data.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data/in_mode qualify.
REQ-010 SHALL have port in_mode, input, 2 bits: 00 sum, 01 avg, 10 max, 11 min.
REQ-011 SHALL have port in_data, input, W_IN*N_IN bits: lane i at in_data[i*W_IN +: W_IN].
REQ-012 SHALL have port out_valid, output, 1 bit: out_data/out_mode valid.
REQ-013 SHALL have port out_mode, output, 2 bits: mode of the current result.
REQ-014 SHALL have port out_data, output, W_OUT bits: signed reduction result.

Function
REQ-015 SHALL implement LOG2N registered stages; stage k (1..LOG2N) SHALL hold N_IN/2^k entries, each combining entries 2j and 2j+1 of stage k-1 (stage 0 = input lanes).
REQ-016 Each stage SHALL carry its own valid bit and 2-bit mode, propagated alongside the data.
REQ-017 Latency SHALL be exactly LOG2N en-high cycles from input acceptance to out_valid; throughput SHALL be one vector per en-high cycle.
REQ-018 Input SHALL be accepted on a rising edge with en=1, flush=0, in_valid=1.
REQ-019 Sum/avg: stage k entry width SHALL be W_IN+k, operands sign-extended, with no overflow possible.
REQ-020 Max/min: signed compare; the result SHALL be sign-extended to stage width; ties SHALL be numerically identical.
REQ-021 Avg: the final stage SHALL register the full sum arithmetically shifted right by LOG2N (floor toward minus infinity), sign-extended to W_OUT.
REQ-022 out_data/out_mode/out_valid SHALL be driven directly from final-stage registers, with no combinational path from inputs.
REQ-023 When en=0 and flush=0, all stage data, mode and valid registers SHALL hold their values.
REQ-024 A stage's data/mode registers SHALL load only when its incoming valid=1 and en=1; when its incoming valid=0 they hold, and the valid bit SHALL load 0.
REQ-025 flush=1 SHALL clear all valid bits on the next edge regardless of en; input presented in the same cycle SHALL be discarded.
REQ-026 Outputs SHALL be meaningful only when out_valid=1; out_data SHALL hold its last value while out_valid=0.
REQ-027 Mode changes between consecutive vectors SHALL NOT affect vectors already in flight.

Reset
REQ-028 rst=1 SHALL asynchronously clear all stage valid, mode and data registers to 0, giving out_valid=0, out_mode=00, out_data=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight vectors; the first valid output after release SHALL correspond to an input accepted after release.
REQ-030 Deassertion SHALL take effect at a rising clk edge; no input SHALL be accepted while rst=1.

Verification (N_IN=4, W_IN=8, W_OUT=10, latency 2)
REQ-031 Sum, lanes {127,127,127,127}, en=1 -> out_valid high 2 cycles later, out_data=508, out_mode=00.
REQ-032 Avg: {1,2,3,-7} -> out_data=-1 (sum -1 >> 2); {-128,-128,-128,-128} -> -128.
REQ-033 Max {-5,3,-100,2} -> 3; min of the same vector -> -100; both outputs sign-extended to 10 bits.
REQ-034 Three back-to-back vectors in modes sum/max/avg -> three consecutive out_valid cycles, in order, each with the correct out_mode and result.
REQ-035 Vector accepted, then en=0 for 3 cycles mid-flight -> out_valid appears exactly 3 cycles late with an unchanged value; flush with 2 vectors in flight plus a concurrent in_valid -> no out_valid thereafter.
REQ-036 rst pulsed asynchronously (between edges) with vectors in flight -> outputs zero immediately; no stale out_valid after release.
